// File: rtl/ram_uart_sender.sv
// ram_uart_sender: drains BYTE_COUNT bytes from a single-port RAM (1-cycle
// read latency) starting at BASE_ADDR and serialises them on uart_txd as
// 8N1, LSB first. Pulses done after the final stop bit.
// Optional feature: define RAM_UART_SENDER_PARITY_EN to insert an even
// parity bit between the data bits and the stop bit (8E1 framing).
module ram_uart_sender #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_W     = 15,
  parameter int BASE_ADDR  = 0,
  parameter int BYTE_COUNT = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              uart_txd,
  output logic              busy,
  output logic              done
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(BYTE_COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    RD,
    LATCH,
    START,
    DATA,
`ifdef RAM_UART_SENDER_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE,
    ABORT
  } state_t;

  state_t            state;
  logic              armed;
  logic [ADDR_W-1:0] byte_idx;
  logic [2:0]        bit_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shift;
`ifdef RAM_UART_SENDER_PARITY_EN
  logic              parity;
`endif

  // Transfer sequencer: fetches each byte, shifts it out bit by bit and
  // handles completion/abort; all outputs are registered here. Reset leaves
  // the block armed so a controller holding start through reset gets a
  // fresh transfer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      armed    <= 1'b1;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shift    <= '0;
`ifdef RAM_UART_SENDER_PARITY_EN
      parity   <= 1'b0;
`endif
      ram_addr <= BASE;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && armed) begin
            busy     <= 1'b1;
            byte_idx <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          ram_addr <= BASE + byte_idx;
          state    <= RD;
        end
        RD: begin
          state <= LATCH;
        end
        LATCH: begin
          shift    <= ram_dout;
`ifdef RAM_UART_SENDER_PARITY_EN
          parity   <= ^ram_dout;
`endif
          uart_txd <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef RAM_UART_SENDER_PARITY_EN
              uart_txd <= parity;
              state    <= PARITY;
`else
              uart_txd <= 1'b1;
              state    <= STOP;
`endif
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              uart_txd <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef RAM_UART_SENDER_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            uart_txd <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_idx == IDX_LAST) begin
              state <= DONE;
            end else if (!start) begin
              state <= ABORT;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= ADDR;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          armed <= 1'b0;
          state <= IDLE;
        end
        ABORT: begin
          busy  <= 1'b0;
          armed <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A low start always re-arms, taking priority over the disarm above.
      if (!start) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_uart_sender.sv
// tb_ram_uart_sender: directed bench for ram_uart_sender. Two instances share
// clock and reset: dut_a (BASE_ADDR=0, BYTE_COUNT=2) and dut_b
// (BASE_ADDR=100, BYTE_COUNT=32). BIT_CYC = 1000000/100000 = 10.
// Build with RAM_UART_SENDER_PARITY_EN defined to exercise the parity frame.
module tb_ram_uart_sender;

  localparam int B = 10;
`ifdef RAM_UART_SENDER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Cycles per byte: ADDR, RD, LATCH plus the line frame.
  localparam int F = NB * B + 3;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start_a   = 1'b0;
  logic        start_b   = 1'b0;
  logic [7:0]  dout_a, dout_b;
  logic [14:0] addr_a, addr_b;
  logic        txd_a, txd_b, busy_a, busy_b, done_a, done_b;

  logic        sel = 1'b0;
  logic        txd_m, busy_m, done_m;
  logic [14:0] addr_m;

  logic [7:0]  mem       [0:255];
  logic [7:0]  exp_bytes [0:31];
  logic        samples   [0:4095];
  int          done_at;
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  assign txd_m  = sel ? txd_b  : txd_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign addr_m = sel ? addr_b : addr_a;

  ram_uart_sender #(
    .CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(15), .BASE_ADDR(0), .BYTE_COUNT(2)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_a), .ram_dout(dout_a),
    .ram_addr(addr_a), .uart_txd(txd_a), .busy(busy_a), .done(done_a)
  );

  ram_uart_sender #(
    .CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(15), .BASE_ADDR(100), .BYTE_COUNT(32)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b), .ram_dout(dout_b),
    .ram_addr(addr_b), .uart_txd(txd_b), .busy(busy_b), .done(done_b)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] mem_rd(input logic [14:0] a);
    if (a < 15'd256) return mem[a[7:0]];
    return 8'h00;
  endfunction

  // Synchronous RAM model with one cycle of read latency.
  always @(posedge sys_clk) begin
    dout_a <= mem_rd(addr_a);
    dout_b <= mem_rd(addr_b);
  end

  // Expected line level for sample j (j=0 is the cycle after accept).
  function automatic logic exp_txd(input int j, input int n);
    int b, o, p;
    if (j >= n * F) return 1'b1;
    b = j / F;
    o = j % F;
    if (o < 3) return 1'b1;
    p = (o - 3) / B;
    if (p == 0) return 1'b0;
    if (p <= 8) return exp_bytes[b][p-1];
`ifdef RAM_UART_SENDER_PARITY_EN
    if (p == 9) return ^exp_bytes[b];
`endif
    return 1'b1;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Waits for accept, then follows the transfer cycle by cycle.
  task automatic run_transfer(input int n, input int base, input bit abort_run, input int drop_at);
    int  total_len;
    bit  found, wave_bad, addr_bad, busy_bad, done_bad;
    logic e;
    total_len = n * F;
    found = 0; wave_bad = 0; addr_bad = 0; busy_bad = 0; done_bad = 0;
    done_at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (busy_m === 1'b1) begin
        found = 1;
        break;
      end
    end
    total_cnt++;
    if (!found) begin
      $display("[TB] FAIL accept: busy=%b after 20 cycles, required 1", busy_m);
      bad_cnt++;
      return;
    end
    for (int j = 0; j <= total_len + 15; j++) begin
      if (j > 0) @(negedge sys_clk);
      samples[j] = txd_m;
      e = exp_txd(j, n);
      if (txd_m !== e && !wave_bad) begin
        $display("[TB] FAIL line_wave: sample %0d txd=%b, required %b", j, txd_m, e);
        wave_bad = 1;
      end
      if (j < total_len && (j % F) != 0 && addr_m !== 15'(base + j / F) && !addr_bad) begin
        $display("[TB] FAIL ram_addr: sample %0d addr=%0d, required %0d", j, addr_m, base + j / F);
        addr_bad = 1;
      end
      if (busy_m !== (j <= total_len) && !busy_bad) begin
        $display("[TB] FAIL busy: sample %0d busy=%b, required %b", j, busy_m, (j <= total_len));
        busy_bad = 1;
      end
      if (done_m !== (!abort_run && j == total_len + 1) && !done_bad) begin
        $display("[TB] FAIL done: sample %0d done=%b, required %b", j, done_m, (!abort_run && j == total_len + 1));
        done_bad = 1;
      end
      if (done_m === 1'b1 && done_at < 0) done_at = j + 1;
      if (j == drop_at) set_start(1'b0);
    end
    total_cnt += 4;
    bad_cnt += int'(wave_bad) + int'(addr_bad) + int'(busy_bad) + int'(done_bad);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    total_cnt += 6;
    if (txd_a !== 1'b1) begin $display("[TB] FAIL rst_txd_a: got %b, required 1", txd_a); bad_cnt++; end
    if (busy_a !== 1'b0) begin $display("[TB] FAIL rst_busy_a: got %b, required 0", busy_a); bad_cnt++; end
    if (done_a !== 1'b0) begin $display("[TB] FAIL rst_done_a: got %b, required 0", done_a); bad_cnt++; end
    if (addr_a !== 15'd0) begin $display("[TB] FAIL rst_addr_a: got %0d, required 0", addr_a); bad_cnt++; end
    if (txd_b !== 1'b1) begin $display("[TB] FAIL rst_txd_b: got %b, required 1", txd_b); bad_cnt++; end
    if (addr_b !== 15'd100) begin $display("[TB] FAIL rst_addr_b: got %0d, required 100", addr_b); bad_cnt++; end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_two_bytes;
    int done_req;
    sel = 1'b0;
`ifdef RAM_UART_SENDER_PARITY_EN
    exp_bytes[0] = 8'h07; exp_bytes[1] = 8'h03;
    done_req = 228;
`else
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h3C;
    done_req = 208;
`endif
    set_start(1'b1);
    run_transfer(2, 0, 1'b0, -1);
    total_cnt++;
    if (done_at !== done_req) begin
      $display("[TB] FAIL done_latency: done at cycle %0d, required %0d", done_at, done_req);
      bad_cnt++;
    end
  endtask

`ifdef RAM_UART_SENDER_PARITY_EN
  task automatic test_parity;
    total_cnt += 4;
    if (samples[98] !== 1'b1) begin $display("[TB] FAIL parity_07: got %b, required 1", samples[98]); bad_cnt++; end
    if (samples[211] !== 1'b0) begin $display("[TB] FAIL parity_03: got %b, required 0", samples[211]); bad_cnt++; end
    if (samples[112] !== 1'b1) begin $display("[TB] FAIL parity_stop: got %b, required 1", samples[112]); bad_cnt++; end
    if (samples[116] !== 1'b0) begin $display("[TB] FAIL parity_frame_len: got %b, required 0", samples[116]); bad_cnt++; end
  endtask
`endif

  task automatic test_no_retrigger;
    bit idle_bad;
    idle_bad = 0;
    sel = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if ((txd_a !== 1'b1 || busy_a !== 1'b0) && !idle_bad) begin
        $display("[TB] FAIL retrigger: cycle %0d txd=%b busy=%b, required 1 0", k, txd_a, busy_a);
        idle_bad = 1;
      end
    end
    total_cnt++;
    bad_cnt += int'(idle_bad);
    set_start(1'b0);
    @(negedge sys_clk);
    set_start(1'b1);
    run_transfer(2, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_frame;
    bit found;
    found = 0;
    sel = 1'b0;
    set_start(1'b0);
    @(negedge sys_clk);
    set_start(1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (busy_a === 1'b1) begin
        found = 1;
        break;
      end
    end
    total_cnt++;
    if (!found) begin
      $display("[TB] FAIL mid_accept: busy=%b after 20 cycles, required 1", busy_a);
      bad_cnt++;
      return;
    end
    // Sample 47 is inside data bit 3, which is 0 for both 0xA5 and 0x07.
    repeat (47) @(negedge sys_clk);
    total_cnt++;
    if (txd_a !== 1'b0) begin $display("[TB] FAIL mid_bit3: got %b, required 0", txd_a); bad_cnt++; end
    #2 sys_rst_n = 1'b0;
    #1;
    total_cnt += 3;
    if (txd_a !== 1'b1) begin $display("[TB] FAIL mid_rst_txd: got %b, required 1", txd_a); bad_cnt++; end
    if (busy_a !== 1'b0) begin $display("[TB] FAIL mid_rst_busy: got %b, required 0", busy_a); bad_cnt++; end
    if (addr_a !== 15'd0) begin $display("[TB] FAIL mid_rst_addr: got %0d, required 0", addr_a); bad_cnt++; end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_transfer(2, 0, 1'b0, -1);
  endtask

  task automatic test_abort;
    sel = 1'b1;
    for (int i = 0; i < 32; i++) exp_bytes[i] = 8'(i);
    set_start(1'b1);
    run_transfer(2, 100, 1'b1, 150);
  endtask

  task automatic test_base_offset;
    int done_req;
`ifdef RAM_UART_SENDER_PARITY_EN
    done_req = 3618;
`else
    done_req = 3298;
`endif
    sel = 1'b1;
    set_start(1'b1);
    run_transfer(32, 100, 1'b0, -1);
    total_cnt++;
    if (done_at !== done_req) begin
      $display("[TB] FAIL done_latency_32: done at cycle %0d, required %0d", done_at, done_req);
      bad_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
`ifdef RAM_UART_SENDER_PARITY_EN
    mem[0] = 8'h07;
    mem[1] = 8'h03;
`else
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
`endif
    for (int i = 0; i < 32; i++) mem[100 + i] = 8'(i);
    #2;
    test_reset;
    test_two_bytes;
`ifdef RAM_UART_SENDER_PARITY_EN
    test_parity;
`endif
    test_no_retrigger;
    test_reset_mid_frame;
    test_abort;
    test_base_offset;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
